regfile_mp: RTL and testbench

Multi-ported, parametrised general-purpose register file for the NPC core, replacing the single-write/dual-read register file. It provides NUM_RD combinational read ports and NUM_WR synchronous write ports, with a deterministic priority rule for same-address writes. Register 0 is optionally hardwired to zero. After reset, a hardware clear sweep zeroes every entry, so the core starts from a known architectural state without a reset fan-out to every flop.

---
 rtl/regfile_mp_if.sv | 42 ++++
 rtl/regfile_mp.sv | 153 +++++++++++++++
 tb/tb_regfile_mp.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// ---------------------------------------------------------------------------
// regfile_mp_if
// Bus bundle for the multi-ported register file. It groups the write ports,
// the read ports and the status flags so that the core and the register file
// share one typed connection.
//
// Signals (packed per port, port i at [i*WIDTH +: WIDTH]):
//   ready        register file -> core  clear sweep finished, file usable
//   wen          core -> register file  per write-port enable
//   waddr/wdata  core -> register file  write address / data
//   raddr        core -> register file  read addresses
//   rdata        register file -> core  read data (combinational)
//   wr_conflict  register file -> core  same-address multi-write last edge
//
// Modports: master = core side, slave = register file side.
// ---------------------------------------------------------------------------
interface regfile_mp_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1
);

  logic                         ready;
  logic [NUM_WR-1:0]            wen;
  logic [NUM_WR*ADDR_WIDTH-1:0] waddr;
  logic [NUM_WR*DATA_WIDTH-1:0] wdata;
  logic [NUM_RD*ADDR_WIDTH-1:0] raddr;
  logic [NUM_RD*DATA_WIDTH-1:0] rdata;
  logic                         wr_conflict;

  modport master (
    input  ready, rdata, wr_conflict,
    output wen, waddr, wdata, raddr
  );

  modport slave (
    output ready, rdata, wr_conflict,
    input  wen, waddr, wdata, raddr
  );

endinterface

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Parametrised general-purpose register file with NUM_RD combinational read
// ports and NUM_WR synchronous write ports. When two enabled write ports hit
// the same entry, the higher-indexed port wins and wr_conflict pulses on the
// following cycle. After reset a clear sweep zeroes one entry per clock, so
// the storage array itself needs no reset. Entry 0 can be hardwired to zero.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   rf   regfile_mp_if.slave bundle (ready, wen, waddr, wdata, raddr,
//        rdata, wr_conflict)
//
// Optional feature:
//   REGFILE_BYPASS_EN  when defined, write data is forwarded to matching read
//                      ports in the same cycle (highest-indexed port wins,
//                      address 0 is never forwarded when ZERO_REG=1).
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int ZERO_REG   = 1
) (
  input logic          clk,
  input logic          rst,
  regfile_mp_if.slave  rf
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   clrCnt_q;
  logic                    ready_q;
  logic                    wrConflict_q;
  logic                    wrConflict_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0]   wAddr [NUM_WR];
  logic [DATA_WIDTH-1:0]   wData [NUM_WR];
  logic [ADDR_WIDTH-1:0]   rAddr [NUM_RD];
  logic [NUM_RD*DATA_WIDTH-1:0] rdataComb;

  // Unpack the flat port buses into per-port arrays so the rest of the
  // logic can index ports directly instead of repeating the slice math.
  always_comb begin
    for (int i = 0; i < NUM_WR; i++) begin
      wAddr[i] = rf.waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wData[i] = rf.wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int j = 0; j < NUM_RD; j++) begin
      rAddr[j] = rf.raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // A conflict is any pair of enabled write ports aiming at the same entry.
  // Address 0 counts too, even when those writes are dropped, because the
  // core still issued two colliding writes.
  always_comb begin
    wrConflict_d = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int k = i + 1; k < NUM_WR; k++) begin
        if (rf.wen[i] && rf.wen[k] && (wAddr[i] == wAddr[k])) begin
          wrConflict_d = 1'b1;
        end
      end
    end
  end

  // Control FSM. CLEAR walks clrCnt_q across every entry; the edge that
  // clears the last entry moves to READY, and the counter wraps back to zero
  // on that same edge. The conflict flag is only ever raised from READY, so
  // writes attempted during the sweep can never report a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      clrCnt_q     <= '0;
      ready_q      <= 1'b0;
      wrConflict_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          clrCnt_q     <= clrCnt_q + CNT_ONE;
          wrConflict_q <= 1'b0;
          if (&clrCnt_q) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: begin
          wrConflict_q <= wrConflict_d;
        end
      endcase
    end
  end

  // Storage array. It has no reset term at all: the sweep zeroes it instead.
  // In READY the ports are applied in ascending order, so when two ports hit
  // the same entry the later (higher-indexed) non-blocking write wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_q[clrCnt_q] <= '0;
      end else begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (rf.wen[i] && !((ZERO_REG != 0) && (wAddr[i] == '0))) begin
            mem_q[wAddr[i]] <= wData[i];
          end
        end
      end
    end
  end

  // Read ports. Start from the stored value, optionally forward same-cycle
  // write data, then apply the overrides: entry 0 reads zero when hardwired,
  // and every port reads zero until the sweep has finished.
  always_comb begin
    logic [DATA_WIDTH-1:0] rdVal;
    rdataComb = '0;
    rdVal     = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      rdVal = mem_q[rAddr[j]];
`ifdef REGFILE_BYPASS_EN
      for (int i = 0; i < NUM_WR; i++) begin
        if (rf.wen[i] && (wAddr[i] == rAddr[j])) begin
          rdVal = wData[i];
        end
      end
`else
`endif
      if ((ZERO_REG != 0) && (rAddr[j] == '0)) begin
        rdVal = '0;
      end
      if (state_q != READY) begin
        rdVal = '0;
      end
      rdataComb[j*DATA_WIDTH +: DATA_WIDTH] = rdVal;
    end
  end

  assign rf.rdata       = rdataComb;
  assign rf.ready       = ready_q;
  assign rf.wr_conflict = wrConflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
// Directed bench for regfile_mp. Two instances share clock and reset:
//   dutA: NUM_WR=2, ZERO_REG=1 (conflicts, bypass, hardwired entry 0)
//   dutB: NUM_WR=1, ZERO_REG=0 (entry 0 behaves like any other register)
// Expected values are written out by hand at each step.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   edgeCount;

  regfile_mp_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(2)) busA ();
  regfile_mp_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(1)) busB ();

  regfile_mp #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
  ) dutA (
    .clk (clk),
    .rst (rst),
    .rf  (busA)
  );

  regfile_mp #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(0)
  ) dutB (
    .clk (clk),
    .rst (rst),
    .rf  (busB)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and sit 1 unit after it, so all
  // sampling happens away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive both write ports of dutA.
  task automatic applyStimulus(input logic [1:0] wen, input logic [4:0] a0,
                               input logic [31:0] d0, input logic [4:0] a1,
                               input logic [31:0] d1);
    busA.wen   = wen;
    busA.waddr = {a1, a0};
    busA.wdata = {d1, d0};
  endtask

  // Drive the single write port of dutB.
  task automatic writeB(input logic wen, input logic [4:0] a, input logic [31:0] d);
    busB.wen   = wen;
    busB.waddr = a;
    busB.wdata = d;
  endtask

  // Both DUTs always read the same pair of addresses.
  task automatic setRead(input logic [4:0] r0, input logic [4:0] r1);
    busA.raddr = {r1, r0};
    busB.raddr = {r1, r0};
    #1;
  endtask

  // One comparison: count it, and report tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Count edges until dutA reports ready, bounded so a stuck sweep ends.
  task automatic waitReady(output int n);
    n = 0;
    while (!busA.ready && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    writeB(1'b0, 5'd0, 32'h0);
    setRead(5'd7, 5'd7);

    // Reset state
    tick();
    tick();
    checkOutput("rst_readyA", {31'b0, busA.ready}, 32'd0);
    checkOutput("rst_readyB", {31'b0, busB.ready}, 32'd0);
    checkOutput("rst_conflict", {31'b0, busA.wr_conflict}, 32'd0);
    checkOutput("rst_rdata", busA.rdata[31:0], 32'h0);

    // First sweep
    rst = 1'b0;
    waitReady(edgeCount);
    checkOutput("clear_len", edgeCount, 32'd32);
    checkOutput("clear_readyB", {31'b0, busB.ready}, 32'd1);

    // Pre-fill entry 7 in both instances
    applyStimulus(2'b01, 5'd7, 32'hDEADBEEF, 5'd0, 32'h0);
    writeB(1'b1, 5'd7, 32'hDEADBEEF);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    writeB(1'b0, 5'd0, 32'h0);
    setRead(5'd7, 5'd7);
    checkOutput("prefill_A", busA.rdata[31:0], 32'hDEADBEEF);
    checkOutput("prefill_B", busB.rdata[31:0], 32'hDEADBEEF);

    // Reset again, and hammer writes on entry 2 during the whole sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(2'b11, 5'd2, 32'h11111111, 5'd2, 32'h22222222);
    writeB(1'b1, 5'd2, 32'h33333333);
    #1;
    checkOutput("clear_rdata_A", busA.rdata[31:0], 32'h0);
    checkOutput("clear_rdata_B", busB.rdata[31:0], 32'h0);

    // Reset mid-sweep after 10 edges
    repeat (10) tick();
    checkOutput("mid_ready", {31'b0, busA.ready}, 32'd0);
    checkOutput("clear_conflict", {31'b0, busA.wr_conflict}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    waitReady(edgeCount);
    checkOutput("resweep_len", edgeCount, 32'd32);
    checkOutput("resweep_conflict", {31'b0, busA.wr_conflict}, 32'd0);
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    writeB(1'b0, 5'd0, 32'h0);
    setRead(5'd2, 5'd7);
    checkOutput("cleared2_A", busA.rdata[31:0], 32'h0);
    checkOutput("cleared7_A", busA.rdata[63:32], 32'h0);
    checkOutput("cleared2_B", busB.rdata[31:0], 32'h0);
    checkOutput("cleared7_B", busB.rdata[63:32], 32'h0);

    // Basic write/read, both read ports on the same address
    applyStimulus(2'b01, 5'd5, 32'h12345678, 5'd0, 32'h0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    setRead(5'd5, 5'd5);
    checkOutput("basic_p0", busA.rdata[31:0], 32'h12345678);
    checkOutput("basic_p1", busA.rdata[63:32], 32'h12345678);
    checkOutput("basic_conflict", {31'b0, busA.wr_conflict}, 32'd0);

    // Zero register: hardwired in dutA, ordinary in dutB
    applyStimulus(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0);
    writeB(1'b1, 5'd0, 32'hFFFFFFFF);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    writeB(1'b0, 5'd0, 32'h0);
    setRead(5'd0, 5'd0);
    checkOutput("zero_A", busA.rdata[31:0], 32'h0);
    checkOutput("zero_B", busB.rdata[31:0], 32'hFFFFFFFF);

    // Same-address conflict on entry 9, port 1 wins
    applyStimulus(2'b11, 5'd9, 32'hAAAA0000, 5'd9, 32'h5555FFFF);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    setRead(5'd9, 5'd9);
    checkOutput("conflict_flag", {31'b0, busA.wr_conflict}, 32'd1);
    checkOutput("conflict_data", busA.rdata[31:0], 32'h5555FFFF);
    tick();
    checkOutput("conflict_pulse", {31'b0, busA.wr_conflict}, 32'd0);

    // Conflict on entry 0 still flags even though the writes are dropped
    applyStimulus(2'b11, 5'd0, 32'h00000001, 5'd0, 32'h00000002);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    setRead(5'd0, 5'd0);
    checkOutput("conflict0_flag", {31'b0, busA.wr_conflict}, 32'd1);
    checkOutput("conflict0_data", busA.rdata[31:0], 32'h0);
    tick();
    checkOutput("conflict0_pulse", {31'b0, busA.wr_conflict}, 32'd0);

    // Two ports writing different entries: no conflict
    applyStimulus(2'b11, 5'd10, 32'h00000001, 5'd11, 32'h00000002);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    setRead(5'd10, 5'd11);
    checkOutput("dual_conflict", {31'b0, busA.wr_conflict}, 32'd0);
    checkOutput("dual_p0", busA.rdata[31:0], 32'h00000001);
    checkOutput("dual_p1", busA.rdata[63:32], 32'h00000002);

    // Bypass: old value in entry 3, then write and read it in one cycle
    applyStimulus(2'b01, 5'd3, 32'h0BADCAFE, 5'd0, 32'h0);
    tick();
    applyStimulus(2'b01, 5'd3, 32'hCAFEF00D, 5'd0, 32'h0);
    setRead(5'd3, 5'd3);
    checkOutput("bypass_same", busA.rdata[31:0], BYPASS ? 32'hCAFEF00D : 32'h0BADCAFE);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #1;
    checkOutput("bypass_after", busA.rdata[31:0], 32'hCAFEF00D);

    // Address 0 is never forwarded on the hardwired instance
    applyStimulus(2'b01, 5'd0, 32'h77777777, 5'd0, 32'h0);
    setRead(5'd0, 5'd3);
    checkOutput("bypass_zero", busA.rdata[31:0], 32'h0);

    // Both ports writing entry 3: forwarding picks port 1
    applyStimulus(2'b11, 5'd3, 32'h00000001, 5'd3, 32'h00000002);
    #1;
    checkOutput("bypass_prio", busA.rdata[63:32], BYPASS ? 32'h00000002 : 32'hCAFEF00D);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #1;
    checkOutput("prio_stored", busA.rdata[63:32], 32'h00000002);
    checkOutput("prio_conflict", {31'b0, busA.wr_conflict}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
